dsp_post_adder_acc: RTL and testbench

//  Post-adder/accumulator stage of the DSP48A1 slice model. Consumes the M-path output (multiplier result after
//  its register/mux pair) plus C, D:A:B and PCIN operands; selects X/Z per OPMODE; computes Z +/- (X + CIN) in

---
 rtl/dsp_pkg.sv | 26 ++
 rtl/dsp_post_adder_core.sv | 60 ++++++
 rtl/dsp_post_adder_acc.sv | 108 ++++++++++
 tb/tb_dsp_post_adder_acc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP post-adder/accumulator slice.
// OPMODE field encodings for the X and Z operand selectors plus the
// bit index of the add/subtract control.
package dsp_pkg;

    // X operand selector, OPMODE[1:0]
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    // Z operand selector, OPMODE[3:2]
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    // OPMODE bit that turns the adder into Z - (X + CIN)
    localparam int OP_SUB = 7;

    // True when either operand mux feeds the current P back into the adder
    function automatic logic is_feedback(input logic [1:0] x_sel, input logic [1:0] z_sel);
        return (x_sel == X_P) || (z_sel == Z_P);
    endfunction

endpackage

// File: rtl/dsp_post_adder_core.sv
// Combinational datapath of the post-adder: X/Z operand muxes, the
// PWIDTH+1 bit add/subtract and signed overflow detection.
module dsp_post_adder_core
    import dsp_pkg::*;
#(
    parameter int PWIDTH = 48,
    parameter int MWIDTH = 36
) (
    input  logic [1:0]        x_sel,
    input  logic [1:0]        z_sel,
    input  logic              sub,
    input  logic              carryin,
    input  logic [MWIDTH-1:0] m,
    input  logic [PWIDTH-1:0] dab,
    input  logic [PWIDTH-1:0] c,
    input  logic [PWIDTH-1:0] pcin,
    input  logic [PWIDTH-1:0] p,
    output logic [PWIDTH-1:0] sum,
    output logic              carryout,
    output logic              overflow
);

    logic [PWIDTH-1:0] x_op;
    logic [PWIDTH-1:0] z_op;
    logic [PWIDTH-1:0] x_eff;
    logic [PWIDTH:0]   full;

    // Select operands, add or subtract, and flag signed overflow. When
    // subtracting, Z - X - CIN equals Z + ~X + ~CIN, so the overflow test
    // compares the sign of Z against the sign of the inverted X operand.
    always_comb begin
        x_op  = '0;
        z_op  = '0;
        x_eff = '0;
        full  = '0;
        case (x_sel)
            X_ZERO:  x_op = '0;
            X_M:     x_op = {{(PWIDTH-MWIDTH){m[MWIDTH-1]}}, m};
            X_P:     x_op = p;
            default: x_op = dab;
        endcase
        case (z_sel)
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = pcin;
            Z_P:     z_op = p;
            default: z_op = c;
        endcase
        if (sub) begin
            full  = {1'b0, z_op} - {1'b0, x_op} - {{PWIDTH{1'b0}}, carryin};
            x_eff = ~x_op;
        end else begin
            full  = {1'b0, z_op} + {1'b0, x_op} + {{PWIDTH{1'b0}}, carryin};
            x_eff = x_op;
        end
        sum      = full[PWIDTH-1:0];
        carryout = full[PWIDTH];
        overflow = (z_op[PWIDTH-1] == x_eff[PWIDTH-1]) && (full[PWIDTH-1] != z_op[PWIDTH-1]);
    end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator stage of the DSP slice: registers P, CARRYOUT,
// the valid flag, sticky overflow and a saturating accumulation count.
// Optional feature macro: PATTERN_DETECT_EN adds PATTERN/MASK inputs and
// the registered Pattern_det output.
module dsp_post_adder_acc
    import dsp_pkg::*;
#(
    parameter int PWIDTH   = 48,
    parameter int MWIDTH   = 36,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic                CE,
    input  logic                Clear,
    input  logic                In_valid,
    input  logic [7:0]          OPMODE,
    input  logic                CARRYIN,
    input  logic [MWIDTH-1:0]   M,
    input  logic [PWIDTH-1:0]   DAB,
    input  logic [PWIDTH-1:0]   C,
    input  logic [PWIDTH-1:0]   PCIN,
`ifdef PATTERN_DETECT_EN
    input  logic [PWIDTH-1:0]   PATTERN,
    input  logic [PWIDTH-1:0]   MASK,
    output logic                Pattern_det,
`endif
    output logic [PWIDTH-1:0]   P,
    output logic                CARRYOUT,
    output logic                Out_valid,
    output logic                Overflow,
    output logic [CNTWIDTH-1:0] Acc_count
);

    logic [PWIDTH-1:0] sum;
    logic              carry;
    logic              ovf;
    logic              feedback;
    logic [2:0]        unused_opmode;

    assign unused_opmode = OPMODE[6:4];
    assign feedback      = is_feedback(OPMODE[1:0], OPMODE[3:2]);

    dsp_post_adder_core #(
        .PWIDTH (PWIDTH),
        .MWIDTH (MWIDTH)
    ) u_core (
        .x_sel    (OPMODE[1:0]),
        .z_sel    (OPMODE[3:2]),
        .sub      (OPMODE[OP_SUB]),
        .carryin  (CARRYIN),
        .m        (M),
        .dab      (DAB),
        .c        (C),
        .pcin     (PCIN),
        .p        (P),
        .sum      (sum),
        .carryout (carry),
        .overflow (ovf)
    );

    // Result, flag and count registers; Clear wins over CE and the operation
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            P         <= '0;
            CARRYOUT  <= 1'b0;
            Out_valid <= 1'b0;
            Overflow  <= 1'b0;
            Acc_count <= '0;
        end else if (Clear) begin
            P         <= '0;
            CARRYOUT  <= 1'b0;
            Out_valid <= 1'b0;
            Overflow  <= 1'b0;
            Acc_count <= '0;
        end else if (CE) begin
            Out_valid <= In_valid;
            if (In_valid) begin
                P        <= sum;
                CARRYOUT <= carry;
                if (ovf) begin
                    Overflow <= 1'b1;
                end
                if (feedback && (Acc_count != {CNTWIDTH{1'b1}})) begin
                    Acc_count <= Acc_count + CNTWIDTH'(1);
                end
            end
        end
    end

`ifdef PATTERN_DETECT_EN
    logic pattern_match;

    assign pattern_match = (((sum ^ PATTERN) & ~MASK) == '0);

    // Flag a valid operation whose new P matches PATTERN on the unmasked bits
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pattern_det <= 1'b0;
        end else if (Clear) begin
            Pattern_det <= 1'b0;
        end else if (CE) begin
            Pattern_det <= In_valid && pattern_match;
        end
    end
`endif

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed self-checking bench for dsp_post_adder_acc with hand-computed
// expected values. Covers PATTERN_DETECT_EN when that macro is defined.
module tb_dsp_post_adder_acc;

    localparam int PWIDTH   = 48;
    localparam int MWIDTH   = 36;
    localparam int CNTWIDTH = 16;

    logic                clk = 1'b0;
    logic                Reset_n;
    logic                CE;
    logic                Clear;
    logic                In_valid;
    logic [7:0]          OPMODE;
    logic                CARRYIN;
    logic [MWIDTH-1:0]   M;
    logic [PWIDTH-1:0]   DAB;
    logic [PWIDTH-1:0]   C;
    logic [PWIDTH-1:0]   PCIN;
    logic [PWIDTH-1:0]   P;
    logic                CARRYOUT;
    logic                Out_valid;
    logic                Overflow;
    logic [CNTWIDTH-1:0] Acc_count;
`ifdef PATTERN_DETECT_EN
    logic [PWIDTH-1:0]   PATTERN;
    logic [PWIDTH-1:0]   MASK;
    logic                Pattern_det;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dsp_post_adder_acc #(
        .PWIDTH   (PWIDTH),
        .MWIDTH   (MWIDTH),
        .CNTWIDTH (CNTWIDTH)
    ) dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .CE          (CE),
        .Clear       (Clear),
        .In_valid    (In_valid),
        .OPMODE      (OPMODE),
        .CARRYIN     (CARRYIN),
        .M           (M),
        .DAB         (DAB),
        .C           (C),
        .PCIN        (PCIN),
`ifdef PATTERN_DETECT_EN
        .PATTERN     (PATTERN),
        .MASK        (MASK),
        .Pattern_det (Pattern_det),
`endif
        .P           (P),
        .CARRYOUT    (CARRYOUT),
        .Out_valid   (Out_valid),
        .Overflow    (Overflow),
        .Acc_count   (Acc_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One immediate-assertion comparison
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check every status output in one call
    task automatic checkAll(input string tag, input logic [63:0] p_exp, input logic co_exp,
                            input logic ov_exp, input logic ovf_exp, input logic [63:0] cnt_exp);
        checkOutput({tag, ".P"},         64'(P),         p_exp);
        checkOutput({tag, ".CARRYOUT"},  64'(CARRYOUT),  64'(co_exp));
        checkOutput({tag, ".Out_valid"}, 64'(Out_valid), 64'(ov_exp));
        checkOutput({tag, ".Overflow"},  64'(Overflow),  64'(ovf_exp));
        checkOutput({tag, ".Acc_count"}, 64'(Acc_count), cnt_exp);
    endtask

    initial begin
        Reset_n  = 1'b0;
        CE       = 1'b1;
        Clear    = 1'b0;
        In_valid = 1'b0;
        OPMODE   = 8'h00;
        CARRYIN  = 1'b0;
        M        = '0;
        DAB      = '0;
        C        = '0;
        PCIN     = '0;
`ifdef PATTERN_DETECT_EN
        PATTERN  = '0;
        MASK     = '1;
`endif
        #1;
        checkAll("reset_init", 64'h0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Load P=0x123 via X=DAB, Z=0
        @(negedge clk);
        Reset_n  = 1'b1;
        OPMODE   = 8'h03;
        DAB      = 48'h123;
        In_valid = 1'b1;
        applyStimulus();
        checkAll("load_123", 64'h123, 1'b0, 1'b1, 1'b0, 64'd0);

        // Asynchronous reset between edges clears immediately
        #2;
        Reset_n = 1'b0;
        #1;
        checkAll("async_reset", 64'h0, 1'b0, 1'b0, 1'b0, 64'd0);
        #2;
        Reset_n = 1'b1;

        // MAC: X=M, Z=P, M=3, four valid cycles
        OPMODE   = 8'h09;
        M        = 36'd3;
        In_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkAll($sformatf("mac%0d", i), 64'(3 * i), 1'b0, 1'b1, 1'b0, 64'(i));
        end

        // CE=1, In_valid=0: hold P, drop Out_valid
        In_valid = 1'b0;
        applyStimulus();
        checkAll("idle_hold", 64'd12, 1'b0, 1'b0, 1'b0, 64'd4);

        // Reset pulse mid-accumulation; next MAC starts from P=0
        In_valid = 1'b1;
        Reset_n  = 1'b0;
        #1;
        Reset_n  = 1'b1;
        applyStimulus();
        checkAll("mac_after_reset", 64'd3, 1'b0, 1'b1, 1'b0, 64'd1);

        // Subtract: C - (M + CIN) = 10 - 4
        OPMODE  = 8'h8D;
        C       = 48'd10;
        M       = 36'd3;
        CARRYIN = 1'b1;
        applyStimulus();
        checkAll("sub_10_4", 64'd6, 1'b0, 1'b1, 1'b0, 64'd1);

        // Subtract with borrow: 0 - 1 wraps to all ones
        C       = 48'd0;
        M       = 36'd1;
        CARRYIN = 1'b0;
        applyStimulus();
        checkAll("sub_borrow", 64'hFFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd1);

        // Signed overflow: 0x7FFF_FFFF_FFFF + 1
        OPMODE = 8'h0F;
        C      = 48'h7FFF_FFFF_FFFF;
        DAB    = 48'd1;
        applyStimulus();
        checkAll("ovf_add", 64'h8000_0000_0000, 1'b0, 1'b1, 1'b1, 64'd1);

        // Overflow is sticky across a clean operation
        OPMODE = 8'h03;
        DAB    = 48'd5;
        applyStimulus();
        checkAll("ovf_sticky", 64'd5, 1'b0, 1'b1, 1'b1, 64'd1);

        // CE=0 with a valid feedback op: everything holds
        CE     = 1'b0;
        OPMODE = 8'h0B;
        DAB    = 48'h77;
        applyStimulus();
        checkAll("ce_low_hold", 64'd5, 1'b0, 1'b1, 1'b1, 64'd1);

        // Clear works while CE=0
        Clear = 1'b1;
        applyStimulus();
        checkAll("clear_ce_low", 64'h0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Sign extension of a negative M: X=M, Z=0, M=-2
        Clear  = 1'b0;
        CE     = 1'b1;
        OPMODE = 8'h01;
        M      = 36'hF_FFFF_FFFE;
        applyStimulus();
        checkAll("m_sext", 64'hFFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 64'd0);

        // X=P, Z=PCIN: 0xFFFF_FFFF_FFFE + 3 carries out to 1
        OPMODE = 8'h06;
        PCIN   = 48'd3;
        applyStimulus();
        checkAll("pcin_fb", 64'd1, 1'b1, 1'b1, 1'b0, 64'd1);

        // Clear has priority over a coincident valid feedback op
        Clear  = 1'b1;
        OPMODE = 8'h09;
        M      = 36'd3;
        applyStimulus();
        checkAll("clear_vs_op", 64'h0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Subtract overflow: 0x8000_0000_0000 - 1
        Clear  = 1'b0;
        OPMODE = 8'h8F;
        C      = 48'h8000_0000_0000;
        DAB    = 48'd1;
        applyStimulus();
        checkAll("ovf_sub", 64'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 64'd0);

`ifdef PATTERN_DETECT_EN
        // Pattern detect ignores the low nibble
        PATTERN = 48'h10;
        MASK    = 48'hF;
        OPMODE  = 8'h03;
        DAB     = 48'h1A;
        applyStimulus();
        checkOutput("pat_match.P", 64'(P), 64'h1A);
        checkOutput("pat_match", 64'(Pattern_det), 64'd1);
        DAB = 48'h2A;
        applyStimulus();
        checkOutput("pat_nomatch", 64'(Pattern_det), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
